alu_op_sequencer: RTL and testbench

Upstream stage for the 5-to-32 one-hot decoder in the ALU select path. It accepts opcode commands over a valid/ready handshake into a small FIFO. It presents each opcode as five individual select bits (i1 = MSB … i5 = LSB) that wire directly to the decoder inputs, and holds each opcode stable for a programmable number of cycles. A downstream stall freezes issue, and a synchronous flush discards all queued and in-flight work.

---
 rtl/alu_op_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Opcode sequencer feeding the 5-to-32 select decoder: a FIFO of {op, rep} commands and an
// issue FSM that holds each op for rep+1 cycles. Define ALU_OPSEQ_COUNT_EN to add issued_cnt.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_op,
    input  logic [CNT_W-1:0]         in_rep,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     i1,
    output logic                     i2,
    output logic                     i3,
    output logic                     i4,
    output logic                     i5,
    output logic                     sel_valid,
    output logic                     last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
`ifdef ALU_OPSEQ_COUNT_EN
    ,
    output logic [15:0]              issued_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 5 + CNT_W;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      level_reg;
    logic [AW:0]      level_next;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;
    logic [4:0]       head_op;
    logic [CNT_W-1:0] head_rep;

    // Issue side
    state_t           state_reg;
    state_t           state_next;
    logic [4:0]       op_reg;
    logic [4:0]       op_next;
    logic [CNT_W-1:0] rem_reg;
    logic [CNT_W-1:0] rem_next;

    assign full     = (level_reg == (AW+1)'(DEPTH));
    assign empty    = (level_reg == '0);
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;

    assign head     = mem[rd_ptr_reg];
    assign head_op  = head[EW-1:CNT_W];
    assign head_rep = head[CNT_W-1:0];

    // Storage carries no reset; only pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_op, in_rep};
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        rem_next   = rem_reg;
        pop        = 1'b0;
        if (flush) begin
            state_next = IDLE;
            op_next    = '0;
            rem_next   = '0;
        end else if (!stall) begin
            case (state_reg)
                IDLE: begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                        op_next    = head_op;
                        rem_next   = head_rep;
                    end
                end
                ISSUE: begin
                    if (rem_reg != '0) begin
                        rem_next = rem_reg - CNT_W'(1);
                    end else if (!empty) begin
                        // back-to-back: next op replaces the finished one with no bubble
                        pop      = 1'b1;
                        op_next  = head_op;
                        rem_next = head_rep;
                    end else begin
                        state_next = IDLE;
                        op_next    = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    op_next    = '0;
                    rem_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_next = level_reg + (AW+1)'(1);
                2'b01:   level_next = level_reg - (AW+1)'(1);
                default: level_next = level_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            rem_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            rem_reg    <= rem_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    assign {i1, i2, i3, i4, i5} = op_reg;
    assign sel_valid            = (state_reg == ISSUE);
    assign last                 = (state_reg == ISSUE) && (rem_reg == '0);
    assign busy                 = (state_reg == ISSUE) || !empty;
    assign level                = level_reg;

`ifdef ALU_OPSEQ_COUNT_EN
    // Counts every load into the output register; flush leaves it alone.
    logic [15:0] issued_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt_reg <= '0;
        end else if (pop) begin
            issued_cnt_reg <= issued_cnt_reg + 16'd1;
        end
    end

    assign issued_cnt = issued_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised self-checking bench for alu_op_sequencer against a queue-based command model.
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [4:0]       op;
        logic [CNT_W-1:0] rep;
    } cmd_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_op;
    logic [CNT_W-1:0] in_rep;
    logic             stall;
    logic             flush;
    logic             i1, i2, i3, i4, i5;
    logic             sel_valid;
    logic             last;
    logic             busy;
    logic [2:0]       level;
`ifdef ALU_OPSEQ_COUNT_EN
    logic [15:0]      issued_cnt;
`endif

    alu_op_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rep     (in_rep),
        .stall      (stall),
        .flush      (flush),
        .i1         (i1),
        .i2         (i2),
        .i3         (i3),
        .i4         (i4),
        .i5         (i5),
        .sel_valid  (sel_valid),
        .last       (last),
        .busy       (busy),
        .level      (level)
`ifdef ALU_OPSEQ_COUNT_EN
        ,
        .issued_cnt (issued_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending commands plus the op currently on the select lines.
    cmd_t       q[$];
    logic       m_valid;
    logic [4:0] m_op;
    int         m_left;
    int         m_cnt;
    logic       m_loaded;

    logic        obs_ready, exp_ready;
    logic [10:0] obs_vec, exp_vec;
    int          obs_cnt;

    function automatic logic [10:0] obs_now();
        return {sel_valid, i1, i2, i3, i4, i5, last, busy, level};
    endfunction

    function automatic logic [10:0] exp_now();
        logic [4:0] op_e;
        logic [2:0] lvl;
        op_e = m_valid ? m_op : 5'b00000;
        lvl  = 3'(q.size());
        return {m_valid, op_e, (m_valid && m_left == 0), (m_valid || q.size() > 0), lvl};
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid  = 1'b0;
        m_op     = '0;
        m_left   = 0;
        m_cnt    = 0;
        m_loaded = 1'b0;
    endtask

    // One clock: drive at negedge, sample in_ready before the edge, advance model, sample after.
    task automatic tick(input logic v, input logic [4:0] op, input logic [CNT_W-1:0] rep,
                        input logic st, input logic fl);
        logic acc;
        cmd_t c;
        @(negedge clk);
        in_valid = v; in_op = op; in_rep = rep; stall = st; flush = fl;
        #1;
        obs_ready = in_ready;
        exp_ready = (q.size() < DEPTH) && !fl;
        acc = v && exp_ready;
        @(posedge clk);
        m_loaded = 1'b0;
        if (fl) begin
            q.delete();
            m_valid = 1'b0;
        end else begin
            if (!st) begin
                if (m_valid && m_left > 0) begin
                    m_left--;
                end else if (q.size() > 0) begin
                    c = q.pop_front();
                    m_valid = 1'b1; m_op = c.op; m_left = int'(c.rep);
                    m_cnt++; m_loaded = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (acc) q.push_back('{op: op, rep: rep});
        end
        if (acc) $display("push op=%b rep=%0d queued=%0d", op, rep, q.size());
        #1;
        obs_vec = obs_now();
        exp_vec = exp_now();
`ifdef ALU_OPSEQ_COUNT_EN
        obs_cnt = int'(issued_cnt);
`else
        obs_cnt = m_cnt;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_op = '0; in_rep = '0; stall = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_now() !== 11'd0) begin
            failures++; $display("FAIL reset_outputs got=%b want=%b", obs_now(), 11'd0);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
`ifdef ALU_OPSEQ_COUNT_EN
        checks++;
        if (issued_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d want=0", issued_cnt);
        end
`endif
        $display("reset released");
    endtask

    task automatic test_single();
        int sel_n = 0, first = -1, last_at = -1, last_n = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) tick(1, 5'b10110, 4'd2, 0, 0);
            else        tick(0, 5'b00000, 4'd0, 0, 0);
            checks += 2;
            if (obs_ready !== exp_ready) begin
                failures++; $display("FAIL single_ready cyc=%0d got=%b want=%b", i, obs_ready, exp_ready);
            end
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL single_out cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (sel_valid === 1'b1) begin
                sel_n++;
                if (first < 0) first = i;
            end
            if (last === 1'b1) begin last_n++; last_at = i; end
        end
        checks += 3;
        if (sel_n != 3 || first != 1) begin
            failures++; $display("FAIL single_len got=%0d@%0d want=3@1", sel_n, first);
        end
        if (last_n != 1 || last_at != 3) begin
            failures++; $display("FAIL single_last got=%0d@%0d want=1@3", last_n, last_at);
        end
        if ({i1, i2, i3, i4, i5} !== 5'b00000) begin
            failures++; $display("FAIL single_idle_op got=%b want=00000", {i1, i2, i3, i4, i5});
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [3];
        logic [4:0] seen [$];
        int first = -1, lastn = 0;
        ops[0] = 5'b00001; ops[1] = 5'b11111; ops[2] = 5'b01010;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) tick(1, ops[i], 4'd0, 0, 0);
            else       tick(0, 5'b00000, 4'd0, 0, 0);
            checks += 2;
            if (obs_ready !== exp_ready) begin
                failures++; $display("FAIL b2b_ready cyc=%0d got=%b want=%b", i, obs_ready, exp_ready);
            end
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL b2b_out cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (sel_valid === 1'b1) begin
                if (first < 0) first = i;
                if (i - first == seen.size()) seen.push_back({i1, i2, i3, i4, i5});
                if (last === 1'b1) lastn++;
            end
        end
        checks++;
        if (seen.size() != 3 || lastn != 3) begin
            failures++; $display("FAIL b2b_count got=%0d last=%0d want=3", seen.size(), lastn);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (seen[k] !== ops[k]) begin
                    failures++; $display("FAIL b2b_order idx=%0d got=%b want=%b", k, seen[k], ops[k]);
                end
            end
        end
    endtask

    task automatic test_fill_stall();
        cmd_t pushed [DEPTH];
        int   k = 0;
        for (int i = 0; i < DEPTH; i++) begin
            pushed[i].op  = 5'($urandom);
            pushed[i].rep = CNT_W'($urandom_range(0, 2));
            tick(1, pushed[i].op, pushed[i].rep, 1, 0);
            checks += 2;
            if (obs_ready !== exp_ready) begin
                failures++; $display("FAIL fill_ready cyc=%0d got=%b want=%b", i, obs_ready, exp_ready);
            end
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL fill_out cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
        end
        tick(1, 5'b11011, 4'd1, 1, 0);
        checks += 2;
        if (obs_ready !== 1'b0) begin
            failures++; $display("FAIL full_ready got=%b want=0", obs_ready);
        end
        if (level !== 3'd4) begin
            failures++; $display("FAIL full_level got=%0d want=4", level);
        end
        for (int i = 0; i < 40 && (k < DEPTH || busy === 1'b1); i++) begin
            tick(0, 5'b00000, 4'd0, 0, 0);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL drain_out cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (m_loaded && k < DEPTH) begin
                checks++;
                if ({i1, i2, i3, i4, i5} !== pushed[k].op) begin
                    failures++; $display("FAIL drain_order idx=%0d got=%b want=%b", k, {i1, i2, i3, i4, i5}, pushed[k].op);
                end
                k++;
            end
        end
        checks++;
        if (k != DEPTH || busy !== 1'b0) begin
            failures++; $display("FAIL drain_done got=%0d busy=%b want=%0d busy=0", k, busy, DEPTH);
        end
    endtask

    task automatic test_stall_mid();
        int sel_n = 0;
        for (int i = 0; i < 10; i++) begin
            tick(i == 0, 5'b01101, 4'd3, (i >= 3 && i <= 5), 0);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL stall_out cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (sel_valid === 1'b1) sel_n++;
        end
        checks++;
        if (sel_n != 7) begin
            failures++; $display("FAIL stall_len got=%0d want=7", sel_n);
        end
        for (int i = 0; i < 8; i++) begin
            tick(i == 0, 5'b10011, 4'd1, (i == 3 || i == 4), 0);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL stall_last_out cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (i >= 2 && i <= 4) begin
                checks++;
                if (last !== 1'b1 || {i1, i2, i3, i4, i5} !== 5'b10011) begin
                    failures++; $display("FAIL stall_last cyc=%0d got=%b want=1", i, last);
                end
            end
        end
    endtask

    task automatic test_flush();
        tick(1, 5'b00111, 4'd15, 0, 0);
        tick(1, 5'b01000, 4'd0, 0, 0);
        tick(1, 5'b01001, 4'd0, 0, 0);
        checks++;
        if (level !== 3'd2 || sel_valid !== 1'b1) begin
            failures++; $display("FAIL preflush got=lvl%0d sv%b want=lvl2 sv1", level, sel_valid);
        end
        tick(1, 5'b11100, 4'd2, 0, 1);
        checks += 3;
        if (obs_ready !== 1'b0) begin
            failures++; $display("FAIL flush_ready got=%b want=0", obs_ready);
        end
        if (sel_valid !== 1'b0 || level !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL flush_state got=sv%b lvl%0d busy%b want=0", sel_valid, level, busy);
        end
        if (obs_cnt != m_cnt) begin
            failures++; $display("FAIL flush_cnt got=%0d want=%0d", obs_cnt, m_cnt);
        end
        tick(0, 5'b00000, 4'd0, 0, 0);
        checks++;
        if (obs_vec !== exp_vec || sel_valid !== 1'b0) begin
            failures++; $display("FAIL postflush got=%b want=%b", obs_vec, exp_vec);
        end
    endtask

    task automatic test_async_reset();
        tick(1, 5'b11001, 4'd5, 0, 0);
        tick(0, 5'b00000, 4'd0, 0, 0);
        tick(1, 5'b00110, 4'd1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_now() !== 11'd0) begin
            failures++; $display("FAIL async_reset got=%b want=%b", obs_now(), 11'd0);
        end
        model_reset();
        @(negedge clk); in_valid = 0; #2 rst_n = 1'b1;
        $display("async reset pulse done");
        for (int i = 0; i < 6; i++) begin
            tick(i == 0, 5'b10101, 4'd1, 0, 0);
            checks++;
            if (obs_vec !== exp_vec || obs_cnt != m_cnt) begin
                failures++; $display("FAIL post_reset cyc=%0d got=%b/%0d want=%b/%0d", i, obs_vec, obs_cnt, exp_vec, m_cnt);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 99) < 60, 5'($urandom), CNT_W'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3);
            checks += 3;
            if (obs_ready !== exp_ready) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", i, obs_ready, exp_ready);
            end
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL rand_out cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (obs_cnt != m_cnt) begin
                failures++; $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", i, obs_cnt, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill_stall();
        test_stall_mid();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
